// File: rtl/color_filter_pkg.sv
// Shared register map, reset constants, control-word layout and small helpers
// for the colour filter block.
package color_filter_pkg;

  localparam logic [3:0] REG_CTRL    = 4'h0;
  localparam logic [3:0] REG_GAIN    = 4'h4;
  localparam logic [3:0] REG_PIXCNT  = 4'h8;
  localparam logic [3:0] REG_SCRATCH = 4'hC;

  localparam logic [31:0] CTRL_RST    = 32'h0000_0000;
  localparam logic [31:0] GAIN_RST    = 32'h8080_8080;
  localparam logic [31:0] PIXCNT_RST  = 32'h0000_0000;
  localparam logic [31:0] SCRATCH_RST = 32'h0000_0000;

  // Q1.7 value of 1.0: pass and isolate reuse the gain datapath with this factor.
  localparam logic [7:0] UNITY_GAIN = 8'h80;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_ISOLATE = 2'd1,
    MODE_GAIN    = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef struct packed {
    logic [25:0] rsvd_hi;
    logic [1:0]  sel;
    logic        rsvd_lo;
    mode_e       mode;
    logic        en;
  } ctrl_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [7:0] chan_gain(input mode_e mode, input logic [1:0] sel,
                                           input logic [7:0] gain, input int ch);
    logic [7:0] g;
    case (mode)
      MODE_ISOLATE: g = (int'(sel) == ch) ? UNITY_GAIN : 8'h00;
      MODE_GAIN:    g = gain;
      default:      g = UNITY_GAIN;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/color_filter_pipe.sv
// Two-stage pixel filter (multiply, then shift/saturate); 2-cycle latency, 1 pixel/cycle.
// Both stages advance only when the output slot is empty or being taken, so stalls never drop beats.
module color_filter_pipe
  import color_filter_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CH_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  mode_e                  mode,
  input  logic [1:0]             sel,
  input  logic [NUM_CH*8-1:0]    gain,
  input  logic [NUM_CH*CH_W-1:0] s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [NUM_CH*CH_W-1:0] m_tdata,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready
);

  localparam int PW = CH_W + 8;

  logic                   ce;
  logic                   v1;
  logic                   last1;
  logic [NUM_CH*PW-1:0]   prod;
  logic [NUM_CH*PW-1:0]   prod_q;
  logic [NUM_CH*CH_W-1:0] out_d;

  function automatic logic [CH_W-1:0] sat(input logic [PW-1:0] p);
    logic [CH_W:0] q;
    q = p[PW-1:7];
    return q[CH_W] ? {CH_W{1'b1}} : q[CH_W-1:0];
  endfunction

  assign ce       = !m_tvalid || m_tready;
  assign s_tready = en && ce;

  always_comb begin
    prod = '0;
    for (int k = 0; k < NUM_CH; k++)
      prod[k*PW +: PW] = PW'(s_tdata[k*CH_W +: CH_W]) * PW'(chan_gain(mode, sel, gain[k*8 +: 8], k));
  end

  always_comb begin
    out_d = '0;
    for (int k = 0; k < NUM_CH; k++)
      out_d[k*CH_W +: CH_W] = sat(prod_q[k*PW +: PW]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      last1    <= 1'b0;
      prod_q   <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
    end else if (ce) begin
      v1       <= s_tvalid && s_tready;
      last1    <= s_tlast;
      prod_q   <= prod;
      m_tvalid <= v1;
      m_tlast  <= last1;
      m_tdata  <= out_d;
    end
  end

endmodule

// File: rtl/color_filter_axil.sv
// AXI4-Lite register slave + frame-shadowed config around color_filter_pipe; stream latency 2 cycles,
// s_pix_tready = EN && output slot free. PIXCNT exists only with COLOR_FILTER_PIXCNT_EN defined.
module color_filter_axil
  import color_filter_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_CH             = 3,
  parameter int CH_W               = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [NUM_CH*CH_W-1:0]          s_pix_tdata,
  input  logic                            s_pix_tvalid,
  input  logic                            s_pix_tlast,
  output logic                            s_pix_tready,
  output logic [NUM_CH*CH_W-1:0]          m_pix_tdata,
  output logic                            m_pix_tvalid,
  output logic                            m_pix_tlast,
  input  logic                            m_pix_tready
);

  logic        aw_done, w_done, wr_en, bvalid, rvalid;
  logic [1:0]  aw_idx;
  logic [3:0]  wr_off, ar_off;
  logic [31:0] wdata_q, rdata_q, rd_mux;
  logic [3:0]  wstrb_q;
  logic [31:0] ctrl_r, gain_r, scratch_r, pixcnt;
  ctrl_t       ctrl;

  logic                 frame_start, s_hs;
  mode_e                sh_mode, cfg_mode;
  logic [1:0]           sh_sel, cfg_sel;
  logic [NUM_CH*8-1:0]  sh_gain, cfg_gain;

  assign ctrl   = ctrl_r;
  assign wr_en  = aw_done && w_done;
  assign wr_off = {aw_idx, 2'b00};
  assign ar_off = {S_AXI_ARADDR[3:2], 2'b00};

  assign S_AXI_AWREADY = !ARESET && !bvalid && !aw_done;
  assign S_AXI_WREADY  = !ARESET && !bvalid && !w_done;
  assign S_AXI_ARREADY = !ARESET && !rvalid;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      bvalid  <= 1'b0;
      aw_idx  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_done <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[3:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_done  <= 1'b1;
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (wr_en) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        bvalid  <= 1'b1;
      end else if (bvalid && S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl_r    <= CTRL_RST;
      gain_r    <= GAIN_RST;
      scratch_r <= SCRATCH_RST;
    end else if (wr_en) begin
      case (wr_off)
        REG_CTRL:    ctrl_r    <= apply_strb(ctrl_r, wdata_q, wstrb_q);
        REG_GAIN:    gain_r    <= apply_strb(gain_r, wdata_q, wstrb_q);
        REG_SCRATCH: scratch_r <= apply_strb(scratch_r, wdata_q, wstrb_q);
        default:     ;
      endcase
    end
  end

`ifdef COLOR_FILTER_PIXCNT_EN
  // A clear landing on the same edge as an output beat wins.
  always_ff @(posedge ACLK) begin
    if (ARESET)
      pixcnt <= PIXCNT_RST;
    else if (wr_en && wr_off == REG_PIXCNT)
      pixcnt <= '0;
    else if (m_pix_tvalid && m_pix_tready)
      pixcnt <= pixcnt + 32'd1;
  end
`else
  assign pixcnt = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (ar_off)
      REG_CTRL:    rd_mux = ctrl_r;
      REG_GAIN:    rd_mux = gain_r;
      REG_PIXCNT:  rd_mux = pixcnt;
      REG_SCRATCH: rd_mux = scratch_r;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid  <= 1'b0;
      rdata_q <= '0;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      rvalid  <= 1'b1;
      rdata_q <= rd_mux;
    end else if (rvalid && S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

  // The first beat of a frame uses the live registers and latches them for the rest of the frame.
  assign s_hs     = s_pix_tvalid && s_pix_tready;
  assign cfg_mode = frame_start ? ctrl.mode : sh_mode;
  assign cfg_sel  = frame_start ? ctrl.sel : sh_sel;
  assign cfg_gain = frame_start ? gain_r[NUM_CH*8-1:0] : sh_gain;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      frame_start <= 1'b1;
      sh_mode     <= MODE_PASS;
      sh_sel      <= '0;
      sh_gain     <= GAIN_RST[NUM_CH*8-1:0];
    end else if (s_hs) begin
      frame_start <= s_pix_tlast;
      if (frame_start) begin
        sh_mode <= ctrl.mode;
        sh_sel  <= ctrl.sel;
        sh_gain <= gain_r[NUM_CH*8-1:0];
      end
    end
  end

  color_filter_pipe #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pipe (
    .clk      (ACLK),
    .rst      (ARESET),
    .en       (ctrl.en),
    .mode     (cfg_mode),
    .sel      (cfg_sel),
    .gain     (cfg_gain),
    .s_tdata  (s_pix_tdata),
    .s_tvalid (s_pix_tvalid),
    .s_tlast  (s_pix_tlast),
    .s_tready (s_pix_tready),
    .m_tdata  (m_pix_tdata),
    .m_tvalid (m_pix_tvalid),
    .m_tlast  (m_pix_tlast),
    .m_tready (m_pix_tready)
  );

  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, ctrl, gain_r};

endmodule

// File: tb/tb_color_filter_axil.sv
// Scoreboard bench for color_filter_axil (NUM_CH=3, CH_W=8); builds with or without COLOR_FILTER_PIXCNT_EN.
module tb_color_filter_axil;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [23:0] s_pix_tdata;
  logic        s_pix_tvalid;
  logic        s_pix_tlast;
  logic        s_pix_tready;
  logic [23:0] m_pix_tdata;
  logic        m_pix_tvalid;
  logic        m_pix_tlast;
  logic        m_pix_tready;

`ifdef COLOR_FILTER_PIXCNT_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int rdy_mode = 1;  // 0 hold low, 1 hold high, 2 random
  logic [24:0] exp_q[$];
  logic [31:0] rd;

  color_filter_axil dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY),
    .s_pix_tdata(s_pix_tdata), .s_pix_tvalid(s_pix_tvalid), .s_pix_tlast(s_pix_tlast),
    .s_pix_tready(s_pix_tready), .m_pix_tdata(m_pix_tdata), .m_pix_tvalid(m_pix_tvalid),
    .m_pix_tlast(m_pix_tlast), .m_pix_tready(m_pix_tready)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference: out = min(pix*gain/128, 255) per channel; isolate keeps channel sel only.
  function automatic logic [23:0] model(input logic [23:0] pix, input int mode, input int sel,
                                        input logic [31:0] gain);
    logic [23:0] r;
    int unsigned p, g, v;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      p = 32'(pix[k*8 +: 8]);
      g = 32'(gain[k*8 +: 8]);
      if (mode == 1)      v = (k == sel) ? p : 0;
      else if (mode == 2) v = (p * g) / 128;
      else                v = p;
      if (v > 255) v = 255;
      r[k*8 +: 8] = v[7:0];
    end
    return r;
  endfunction

  always begin
    @(posedge ACLK);
    #1;
    if (rdy_mode == 2)      m_pix_tready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 1) m_pix_tready = 1'b1;
    else                    m_pix_tready = 1'b0;
  end

  always @(negedge ACLK) begin
    logic [24:0] e;
    if (!ARESET && m_pix_tvalid && m_pix_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'(m_pix_tdata), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("pix_data", 32'(m_pix_tdata), 32'(e[23:0]));
        chk("pix_last", 32'(m_pix_tlast), 32'(e[24]));
      end
    end
  end

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_ok, w_ok;
    int n;
    aw_ok = 1'b0; w_ok = 1'b0; n = 0;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    while (!(aw_ok && w_ok) && n < 50) begin
      @(negedge ACLK);
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_ok = 1'b1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_ok = 1'b1;
      @(posedge ACLK); #1;
      if (aw_ok) S_AXI_AWVALID = 1'b0;
      if (w_ok) S_AXI_WVALID = 1'b0;
      n++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 50) begin @(posedge ACLK); #1; n++; end
    chk("bvalid", 32'(S_AXI_BVALID), 32'd1);
    chk("bresp", 32'(S_AXI_BRESP), 32'd0);
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    logic ok;
    int n;
    ok = 1'b0; n = 0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    while (!ok && n < 50) begin
      @(negedge ACLK); ok = S_AXI_ARREADY; n++;
      @(posedge ACLK); #1;
    end
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 50) begin @(posedge ACLK); #1; n++; end
    chk("rvalid", 32'(S_AXI_RVALID), 32'd1);
    chk("rresp", 32'(S_AXI_RRESP), 32'd0);
    d = S_AXI_RDATA;
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    chk(tag, d, exp);
  endtask

  task automatic send(input logic [23:0] d, input logic l, input logic [23:0] e);
    logic ok;
    int n;
    ok = 1'b0; n = 0;
    s_pix_tdata = d; s_pix_tlast = l; s_pix_tvalid = 1'b1;
    while (!ok && n < 300) begin
      @(negedge ACLK); ok = s_pix_tready; n++;
      @(posedge ACLK); #1;
    end
    s_pix_tvalid = 1'b0;
    chk("s_accept", 32'(ok), 32'd1);
    if (ok) exp_q.push_back({l, e});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_pix_tvalid) && n < 1000) begin @(posedge ACLK); #1; n++; end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [23:0] d;
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    s_pix_tdata = '0; s_pix_tvalid = 1'b0; s_pix_tlast = 1'b0; m_pix_tready = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    chk("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    chk("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    chk("rst_mvalid", 32'(m_pix_tvalid), 32'd0);
    chk("rst_sready", 32'(s_pix_tready), 32'd0);
    ARESET = 1'b0;
    #1;
    chk("post_rst_awready", 32'(S_AXI_AWREADY), 32'd1);
    chk("post_rst_wready", 32'(S_AXI_WREADY), 32'd1);
    chk("post_rst_arready", 32'(S_AXI_ARREADY), 32'd1);
    @(posedge ACLK); #1;

    // Register reset values and readback
    rd_chk("rst_ctrl", 4'h0, 32'h0);
    rd_chk("rst_gain", 4'h4, 32'h8080_8080);
    rd_chk("rst_pixcnt", 4'h8, 32'h0);
    rd_chk("rst_scratch", 4'hC, 32'h0);
    axi_write(4'h0, 32'd1, 4'hF);
    axi_write(4'h4, 32'd2, 4'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'hC, 32'd4, 4'hF);
    rd_chk("rb_ctrl", 4'h0, 32'd1);
    rd_chk("rb_gain", 4'h4, 32'd2);
    rd_chk("rb_pixcnt", 4'h8, 32'd0);
    rd_chk("rb_scratch", 4'hC, 32'd4);
    axi_write(4'hC, 32'h0000_00FF, 4'b0001);
    rd_chk("strb_scratch", 4'hC, 32'h0000_00FF);
    axi_write(4'hC, 32'hAABB_CCDD, 4'b1010);
    rd_chk("strb_scratch2", 4'hC, 32'hAA00_CCFF);

    // Gain mode with saturation and 2-cycle latency
    axi_write(4'h4, 32'h00FF_4080, 4'hF);
    axi_write(4'h0, 32'h5, 4'hF);
    send(24'h10C8F0, 1'b1, 24'h1F64F0);
    chk("lat_stage1", 32'(m_pix_tvalid), 32'd0);
    @(posedge ACLK); #1;
    chk("lat_stage2", 32'(m_pix_tvalid), 32'd1);
    send(24'hFF80FF, 1'b1, model(24'hFF80FF, 2, 0, 32'h00FF_4080));
    drain();

    // Isolate, including an out-of-range select
    axi_write(4'h0, 32'h13, 4'hF);
    send(24'h123456, 1'b1, 24'h003400);
    axi_write(4'h0, 32'h33, 4'hF);
    send(24'h123456, 1'b1, 24'h000000);
    drain();

    // Backpressure ramp in pass mode
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h8, 32'h0, 4'hF);
    rdy_mode = 2;
    for (int i = 0; i < 64; i++) begin
      d = {8'(i) ^ 8'h5A, 8'(i + 1), 8'(i)};
      send(d, 1'(i == 63), model(d, 0, 0, 32'h0));
    end
    drain();
    rdy_mode = 1;
    rd_chk("pixcnt_64", 4'h8, HAS_CNT ? 32'd64 : 32'd0);
    axi_write(4'h8, 32'h0, 4'hF);
    rd_chk("pixcnt_clr", 4'h8, 32'd0);

    // Config change mid-frame applies from the next frame
    for (int i = 0; i < 4; i++) begin
      d = 24'hA1B2C3 + 24'(i * 24'h010101);
      if (i == 2) axi_write(4'h0, 32'h13, 4'hF);
      send(d, 1'(i == 3), model(d, 0, 0, 32'h0));
    end
    for (int i = 0; i < 3; i++) begin
      d = 24'h5E6F70 + 24'(i * 24'h020304);
      send(d, 1'(i == 2), model(d, 1, 1, 32'h0));
    end
    drain();

    // EN=0 stops intake but in-flight beats still exit
    axi_write(4'h0, 32'h5, 4'hF);
    rdy_mode = 0;
    @(posedge ACLK); #1;
    send(24'h204060, 1'b0, model(24'h204060, 2, 0, 32'h00FF_4080));
    send(24'h80FF01, 1'b1, model(24'h80FF01, 2, 0, 32'h00FF_4080));
    axi_write(4'h0, 32'h4, 4'hF);
    chk("en0_sready", 32'(s_pix_tready), 32'd0);
    chk("en0_held_valid", 32'(m_pix_tvalid), 32'd1);
    rdy_mode = 1;
    drain();
    chk("en0_sready_drained", 32'(s_pix_tready), 32'd0);

    // Mid-frame reset flushes the pipe, clears PIXCNT and restarts framing
    axi_write(4'h0, 32'h1, 4'hF);
    rdy_mode = 0;
    @(posedge ACLK); #1;
    send(24'h010203, 1'b0, 24'h010203);
    send(24'h040506, 1'b0, 24'h040506);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    chk("rst_mid_mvalid", 32'(m_pix_tvalid), 32'd0);
    exp_q.delete();
    rdy_mode = 1;
    rd_chk("rst_mid_pixcnt", 4'h8, 32'd0);
    rd_chk("rst_mid_ctrl", 4'h0, 32'd0);
    axi_write(4'h0, 32'h13, 4'hF);
    send(24'h123456, 1'b1, 24'h003400);
    drain();
    rd_chk("final_pixcnt", 4'h8, HAS_CNT ? 32'd1 : 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
